apb_completer: RTL and testbench

- APB completer (peripheral) that sits directly downstream of apb_bridge and answers its read/write transfers.
- Contains a bank of NUM_REGS word-wide registers, applies byte strobes and inserts a programmable number of wait states.
- Flags unaligned, out-of-range and protocol-violating transfers with pslverr.
- Counts errors for debug.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_regbank.sv | 38 +++
 rtl/apb_completer.sv | 183 ++++++++++++++++++
 tb/tb_apb_completer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB completer block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int APB_DATA_WIDTH = 32;
  localparam int STRB_WIDTH     = APB_DATA_WIDTH / 8;
  localparam int ERR_CNT_MAX    = 255;

  // Word accesses only: both byte-offset bits must be zero.
  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/apb_regbank.sv
// Register array with one byte-strobed write port and one combinational read port.
// Latency: writes land on the next clk edge; reads are combinational from the array.
// Backpressure: none; the caller only asserts we_i for in-range indices.
// Ports: clk_i/rst_i (sync, active-high clear), we_i/widx_i/wdata_i/wstrb_i write
//        port, ridx_i/rdata_o read port.
module apb_regbank
  import apb_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      we_i,
  input  logic [IDX_W-1:0]          widx_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0]     wstrb_i,
  input  logic [IDX_W-1:0]          ridx_i,
  output logic [APB_DATA_WIDTH-1:0] rdata_o
);

  logic [APB_DATA_WIDTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= '{default: '0};
    end else if (we_i) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wstrb_i[i]) begin
          regs_q[widx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = regs_q[ridx_i];

endmodule

// File: rtl/apb_completer.sv
// APB completer: register bank with byte strobes, programmable wait states, error flagging.
// Latency: setup sampled at edge S -> pready high after edge S+1+WAIT_STATES for one cycle.
// Backpressure: pready held low for WAIT_STATES access cycles; early psel drop ends in pslverr.
// Ports: pclk/preset (sync, active-high), psel/penable/pwrite/paddr/pwdata/pstrb request,
//        prdata/pready/pslverr response (all registered), err_cnt saturating error count.
module apb_completer
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_WIDTH-1:0] pstrb,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [7:0]            err_cnt
);

  localparam int          IDX_W  = $clog2(NUM_REGS);
  localparam int          WORD_W = ADDR_WIDTH - 2;
  localparam logic [3:0]  WS     = 4'(WAIT_STATES);

  state_e                 state_q,   state_d;
  logic [3:0]             cnt_q,     cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q,    addr_d;
  logic                   write_q,   write_d;
  logic [DATA_WIDTH-1:0]  wdata_q,   wdata_d;
  logic [STRB_WIDTH-1:0]  strb_q,    strb_d;
  logic                   pready_q,  pready_d;
  logic                   pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]  prdata_q,  prdata_d;
  logic [7:0]             err_cnt_q, err_cnt_d;

  logic                   rb_we;
  logic [DATA_WIDTH-1:0]  rb_rdata;
  logic [WORD_W-1:0]      word_idx;
  logic                   xfer_err;
  logic                   setup_seen;
  logic [7:0]             err_cnt_inc;

  // Decode is always done on the latched address, never on the live bus.
  assign word_idx    = addr_q[ADDR_WIDTH-1:2];
  assign xfer_err    = !is_aligned(addr_q[1:0]) || (word_idx >= WORD_W'(NUM_REGS));
  assign setup_seen  = psel && !penable;
  assign err_cnt_inc = (err_cnt_q == 8'(ERR_CNT_MAX)) ? err_cnt_q : err_cnt_q + 8'd1;

  apb_regbank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regbank (
    .clk_i   (pclk),
    .rst_i   (preset),
    .we_i    (rb_we),
    .widx_i  (word_idx[IDX_W-1:0]),
    .wdata_i (wdata_q),
    .wstrb_i (strb_q),
    .ridx_i  (word_idx[IDX_W-1:0]),
    .rdata_o (rb_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    err_cnt_d = err_cnt_q;
    rb_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A lone penable=1 without a preceding setup is simply ignored here.
        if (setup_seen) begin
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          strb_d  = pstrb;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        if (!psel) begin
          // Requester abandoned the transfer: answer with an error, touch nothing.
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          prdata_d  = '0;
          err_cnt_d = err_cnt_inc;
          state_d   = DONE;
        end else if (!penable) begin
          // Fresh setup while waiting restarts the transfer with the new request.
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          strb_d  = pstrb;
          cnt_d   = '0;
        end else if (cnt_q < WS) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          pready_d = 1'b1;
          state_d  = DONE;
          if (xfer_err) begin
            pslverr_d = 1'b1;
            prdata_d  = '0;
            err_cnt_d = err_cnt_inc;
          end else if (write_q) begin
            rb_we     = 1'b1;
            pslverr_d = 1'b0;
            prdata_d  = '0;
          end else begin
            pslverr_d = 1'b0;
            prdata_d  = rb_rdata;
          end
        end
      end

      DONE: begin
        // Response lives for exactly one cycle; a setup here chains straight on.
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        if (setup_seen) begin
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          strb_d  = pstrb;
          cnt_d   = '0;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_apb_completer.sv
// Directed bench for apb_completer: one instance with WAIT_STATES=1, one with WAIT_STATES=2.
// Latency: checks pready rise at S+1+WAIT_STATES and its one-cycle width.
// Backpressure: bench holds penable until pready, bounded by a cycle budget.
module tb_apb_completer;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  bit          sel2;

  logic        psel1, psel2;
  logic [31:0] prdata1, prdata2;
  logic        pready1, pready2, pslverr1, pslverr2;
  logic [7:0]  err_cnt1, err_cnt2;

  logic [31:0] m_prdata;
  logic        m_pready, m_pslverr;
  logic [7:0]  m_err_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int s_edge;
  int lat;
  logic [31:0] rd;
  logic        er;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  assign psel1     = psel & ~sel2;
  assign psel2     = psel &  sel2;
  assign m_prdata  = sel2 ? prdata2  : prdata1;
  assign m_pready  = sel2 ? pready2  : pready1;
  assign m_pslverr = sel2 ? pslverr2 : pslverr1;
  assign m_err_cnt = sel2 ? err_cnt2 : err_cnt1;

  apb_completer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(1)) u_dut1 (
    .pclk(pclk), .preset(preset), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata1), .pready(pready1), .pslverr(pslverr1), .err_cnt(err_cnt1)
  );

  apb_completer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(2)) u_dut2 (
    .pclk(pclk), .preset(preset), .psel(psel2), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata2), .pready(pready2), .pslverr(pslverr2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Drive a setup on the current negedge; return after the setup edge with penable raised.
  task automatic start(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    @(negedge pclk);
    s_edge = cyc;
    chk("pready_low_after_setup", {31'b0, m_pready}, 32'd0);
    penable = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n   = 0;
    lat = -1;
    while (n < 40) begin
      @(negedge pclk);
      n++;
      if (m_pready === 1'b1) begin
        lat = cyc - s_edge;
        break;
      end
    end
    rd = m_prdata;
    er = m_pslverr;
    chk({tag, "_lat"}, lat, sel2 ? 32'd3 : 32'd2);
  endtask

  task automatic idle();
    psel    = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    chk("pready_one_cycle", {31'b0, m_pready}, 32'd0);
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input string tag);
    start(wr, addr, data, strb);
    wait_done(tag);
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; sel2 = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_pready",  {31'b0, pready1},  32'd0);
    chk("rst_pslverr", {31'b0, pslverr1}, 32'd0);
    chk("rst_prdata",  prdata1,           32'd0);
    chk("rst_err_cnt", {24'b0, err_cnt1}, 32'd0);
    preset = 1'b0;

    // Basic write then read-back.
    xfer(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, "wr4");
    chk("wr4_err", {31'b0, er}, 32'd0);
    xfer(1'b0, 32'h4, 32'h0, 4'h0, "rd4");
    chk("rd4_data", rd, 32'hDEADBEEF);
    chk("rd4_err", {31'b0, er}, 32'd0);

    // Partial strobe merge.
    xfer(1'b1, 32'h8, 32'hAABBCCDD, 4'hF, "wr8_pre");
    xfer(1'b1, 32'h8, 32'h12345678, 4'b0011, "wr8_strb");
    xfer(1'b0, 32'h8, 32'h0, 4'hF, "rd8");
    chk("rd8_data", rd, 32'hAABB5678);

    // Zero strobe: no change, no error.
    xfer(1'b1, 32'h4, 32'hFFFFFFFF, 4'h0, "wr4_nostrb");
    chk("nostrb_err", {31'b0, er}, 32'd0);
    xfer(1'b0, 32'h4, 32'h0, 4'h0, "rd4b");
    chk("nostrb_data", rd, 32'hDEADBEEF);

    // Unaligned and out-of-range errors.
    xfer(1'b0, 32'h3, 32'h0, 4'h0, "rd_unal");
    chk("unal_err",  {31'b0, er}, 32'd1);
    chk("unal_data", rd, 32'd0);
    start(1'b1, 32'h40, 32'h99999999, 4'hF);
    wait_done("wr_oor");
    chk("oor_err", {31'b0, er}, 32'd1);
    chk("oor_cnt", {24'b0, m_err_cnt}, 32'd2);
    idle();
    chk("unal_cnt_kept", {24'b0, m_err_cnt}, 32'd2);
    xfer(1'b0, 32'h0, 32'h0, 4'h0, "rd0_oor");
    chk("oor_no_alias_r0", rd, 32'd0);
    xfer(1'b0, 32'h8, 32'h0, 4'h0, "rd8_oor");
    chk("oor_r2_kept", rd, 32'hAABB5678);

    // Back-to-back writes, setup presented on the completion edge.
    start(1'b1, 32'h0, 32'h11111111, 4'hF);
    wait_done("b2b0");
    start(1'b1, 32'h4, 32'h22222222, 4'hF);
    wait_done("b2b1");
    start(1'b1, 32'h8, 32'h33333333, 4'hF);
    wait_done("b2b2");
    chk("b2b2_err", {31'b0, er}, 32'd0);
    idle();
    xfer(1'b0, 32'h0, 32'h0, 4'h0, "b2b_rd0");
    chk("b2b_rd0_data", rd, 32'h11111111);
    xfer(1'b0, 32'h4, 32'h0, 4'h0, "b2b_rd1");
    chk("b2b_rd1_data", rd, 32'h22222222);
    xfer(1'b0, 32'h8, 32'h0, 4'h0, "b2b_rd2");
    chk("b2b_rd2_data", rd, 32'h33333333);

    // Early psel drop on the WAIT_STATES=2 instance.
    sel2 = 1'b1;
    start(1'b1, 32'h4, 32'hCAFEF00D, 4'hF);
    @(negedge pclk);
    chk("abort_wait", {31'b0, m_pready}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk("abort_pready",  {31'b0, m_pready},  32'd1);
    chk("abort_pslverr", {31'b0, m_pslverr}, 32'd1);
    chk("abort_prdata",  m_prdata,           32'd0);
    chk("abort_cnt",     {24'b0, m_err_cnt}, 32'd1);
    @(negedge pclk);
    chk("abort_pready_drop",  {31'b0, m_pready},  32'd0);
    chk("abort_pslverr_drop", {31'b0, m_pslverr}, 32'd0);
    xfer(1'b0, 32'h4, 32'h0, 4'h0, "abort_rd");
    chk("abort_reg_kept", rd, 32'd0);
    chk("abort_rd_err", {31'b0, er}, 32'd0);
    sel2 = 1'b0;

    // Reset during the access wait of a write to 0xC.
    start(1'b1, 32'hC, 32'h55AA55AA, 4'hF);
    @(negedge pclk);
    chk("rstmid_wait", {31'b0, pready1}, 32'd0);
    preset = 1'b1;
    @(negedge pclk);
    chk("rstmid_pready",  {31'b0, pready1},  32'd0);
    chk("rstmid_pslverr", {31'b0, pslverr1}, 32'd0);
    chk("rstmid_prdata",  prdata1,           32'd0);
    chk("rstmid_err_cnt", {24'b0, err_cnt1}, 32'd0);
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk("rstmid_no_pulse", {31'b0, pready1}, 32'd0);
    xfer(1'b0, 32'hC, 32'h0, 4'h0, "rstmid_rd");
    chk("rstmid_reg3", rd, 32'd0);

    // Saturation of the error counter.
    for (int i = 0; i < 256; i++) begin
      start(1'b0, 32'h1, 32'h0, 4'h0);
      wait_done("sat");
      if (i == 0) begin
        chk("sat_first_err", {31'b0, er}, 32'd1);
        chk("sat_first_cnt", {24'b0, m_err_cnt}, 32'd1);
      end
      if (i == 253) chk("sat_254", {24'b0, m_err_cnt}, 32'd254);
      if (i == 254) chk("sat_255", {24'b0, m_err_cnt}, 32'd255);
      idle();
    end
    chk("sat_hold", {24'b0, err_cnt1}, 32'd255);
    xfer(1'b0, 32'h5, 32'h0, 4'h0, "sat_extra");
    chk("sat_hold2", {24'b0, err_cnt1}, 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
